// File: rtl/pc_gen.sv
// -----------------------------------------------------------------------------
// pc_gen : program-counter generator with a circular return-address stack
//
// Purpose
//    Produces the fetch address for a simple in-order core. After reset it
//    leaves IDLE, walks sequentially, and takes redirects from branches,
//    calls/returns, traps and halt requests. Calls push their return address
//    onto a small circular stack. When the stack is full, a push overwrites
//    the oldest entry. All outputs are registered.
//
// Parameters
//    ADDR_W       width of pc and every address port
//    RESET_VECTOR pc held during and right after reset
//    STEP         sequential increment
//    TRAP_VECTOR  pc loaded on trap
//    RAS_DEPTH    return-address-stack entries (2..16)
//
// Ports
//    clk          sole clock, rising edge
//    rst          synchronous active-high reset
//    stall        hold pc, state and stack (trap still wins)
//    branch_flag  redirect to branch_addr
//    branch_addr  branch / call target
//    call_flag    push pc+STEP, redirect to branch_addr
//    ret_flag     pop stack top into pc
//    trap         redirect to TRAP_VECTOR, clear stack, force RUN
//    halt         enter HALTED (left only through trap or rst)
//    pc           current fetch address
//    chip_enable  fetch valid
//    ras_empty    stack holds no entries
//    ras_full     stack holds RAS_DEPTH entries
//    ras_err      one-cycle pulse after a return on an empty stack
// -----------------------------------------------------------------------------
module pc_gen #(
   parameter int                ADDR_W       = 32,
   parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
   parameter int                STEP         = 4,
   parameter logic [ADDR_W-1:0] TRAP_VECTOR  = ADDR_W'(32'h0000_0100),
   parameter int                RAS_DEPTH    = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              branch_flag,
   input  logic [ADDR_W-1:0] branch_addr,
   input  logic              call_flag,
   input  logic              ret_flag,
   input  logic              trap,
   input  logic              halt,
   output logic [ADDR_W-1:0] pc,
   output logic              chip_enable,
   output logic              ras_empty,
   output logic              ras_full,
   output logic              ras_err
);

   // Stack pointer and occupancy widths. The count must be able to hold
   // RAS_DEPTH itself, so it needs one more code than the pointer.
   localparam int PTR_W = (RAS_DEPTH <= 2) ? 1 : $clog2(RAS_DEPTH);
   localparam int CNT_W = $clog2(RAS_DEPTH + 1);

   localparam logic [PTR_W-1:0]  LAST_SLOT = PTR_W'(RAS_DEPTH - 1);
   localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(RAS_DEPTH);
   localparam logic [ADDR_W-1:0] STEP_W    = ADDR_W'(STEP);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } state_t;

   // Registered state
   state_t            state;
   logic [PTR_W-1:0]  top;
   logic [CNT_W-1:0]  count;
   logic [ADDR_W-1:0] stack [RAS_DEPTH];

   // Next-state values
   state_t            state_n;
   logic [ADDR_W-1:0] pc_n;
   logic              ce_n;
   logic              err_n;
   logic [PTR_W-1:0]  top_n;
   logic [CNT_W-1:0]  count_n;
   logic              wr_en;
   logic [PTR_W-1:0]  wr_idx;
   logic [ADDR_W-1:0] wr_val;

   // Helper values shared by several branches of the next-state logic
   logic [ADDR_W-1:0] pc_seq;
   logic [PTR_W-1:0]  top_inc;
   logic [PTR_W-1:0]  top_dec;
   logic              stack_has_data;
   logic              stack_at_full;

   // The pointer wraps explicitly, so depths that are not a power of two
   // still form a proper ring. The occupancy flags come straight from the
   // registered count.
   always_comb begin
      pc_seq         = pc + STEP_W;
      top_inc        = (top == LAST_SLOT) ? '0 : top + PTR_W'(1);
      top_dec        = (top == '0) ? LAST_SLOT : top - PTR_W'(1);
      stack_has_data = (count != '0);
      stack_at_full  = (count == FULL_CNT);
      ras_empty      = !stack_has_data;
      ras_full       = stack_at_full;
   end

   // Next-state logic. In RUN the priority is trap, stall, halt,
   // call (with call+ret as a top replacement), ret, branch, sequential.
   // A call always writes its return address at the new top. On a full
   // stack, advancing the ring pointer lands on the oldest entry, so that
   // entry is the one overwritten.
   always_comb begin
      state_n = state;
      pc_n    = pc;
      err_n   = 1'b0;
      top_n   = top;
      count_n = count;
      wr_en   = 1'b0;
      wr_idx  = top;
      wr_val  = pc_seq;

      case (state)
         IDLE: begin
            state_n = RUN;
            pc_n    = RESET_VECTOR;
         end

         RUN: begin
            if (trap) begin
               pc_n    = TRAP_VECTOR;
               count_n = '0;
            end else if (stall) begin
               pc_n = pc;
            end else if (halt) begin
               state_n = HALTED;
            end else if (call_flag) begin
               pc_n  = branch_addr;
               wr_en = 1'b1;
               if (ret_flag && stack_has_data) begin
                  wr_idx = top;
               end else begin
                  wr_idx = top_inc;
                  top_n  = top_inc;
                  if (!stack_at_full) begin
                     count_n = count + CNT_W'(1);
                  end
               end
            end else if (ret_flag) begin
               if (stack_has_data) begin
                  pc_n    = stack[top];
                  top_n   = top_dec;
                  count_n = count - CNT_W'(1);
               end else begin
                  pc_n  = pc_seq;
                  err_n = 1'b1;
               end
            end else if (branch_flag) begin
               pc_n = branch_addr;
            end else begin
               pc_n = pc_seq;
            end
         end

         HALTED: begin
            if (trap) begin
               state_n = RUN;
               pc_n    = TRAP_VECTOR;
               count_n = '0;
            end
         end

         default: begin
            state_n = IDLE;
            pc_n    = RESET_VECTOR;
            count_n = '0;
         end
      endcase

      // The cycle that leaves IDLE still presents the reset vector without a
      // valid fetch. chip_enable rises once RUN is established, or right
      // away when a trap re-enters RUN from HALTED.
      ce_n = (state_n == RUN) && (state != IDLE);
   end

   // State, pc and outputs update on every edge. Reset overrides all other
   // inputs, including trap. Stack contents are left as they are because
   // the count alone decides which entries are valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         pc          <= RESET_VECTOR;
         chip_enable <= 1'b0;
         ras_err     <= 1'b0;
         top         <= '0;
         count       <= '0;
      end else begin
         state       <= state_n;
         pc          <= pc_n;
         chip_enable <= ce_n;
         ras_err     <= err_n;
         top         <= top_n;
         count       <= count_n;
         if (wr_en) begin
            stack[wr_idx] <= wr_val;
         end
      end
   end

endmodule

// File: tb/tb_pc_gen.sv
// -----------------------------------------------------------------------------
// tb_pc_gen : self-checking bench for pc_gen
//
// A behavioural model keeps the return stack as a queue and the mode as an
// integer. It steps on each rising edge. A negedge process compares every
// DUT output against the model on every cycle. Directed sequences
// also pin literal pc / flag values. A second, 8-bit instance covers
// address wrap at a narrow width.
// -----------------------------------------------------------------------------
module tb_pc_gen;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        branch_flag;
   logic [31:0] branch_addr;
   logic        call_flag;
   logic        ret_flag;
   logic        trap;
   logic        halt;
   logic [31:0] pc;
   logic        chip_enable;
   logic        ras_empty;
   logic        ras_full;
   logic        ras_err;

   logic        rst8;
   logic        branch8;
   logic [7:0]  addr8;
   logic [7:0]  pc8;
   logic        ce8;
   logic        empty8;
   logic        full8;
   logic        err8;

   int          checkCount = 0;
   int          failCount  = 0;
   bit          checkEn    = 1'b0;

   pc_gen #(
      .ADDR_W(32), .RESET_VECTOR(32'h0), .STEP(4),
      .TRAP_VECTOR(32'h0000_0100), .RAS_DEPTH(4)
   ) dut (
      .clk(clk), .rst(rst), .stall(stall), .branch_flag(branch_flag),
      .branch_addr(branch_addr), .call_flag(call_flag), .ret_flag(ret_flag),
      .trap(trap), .halt(halt), .pc(pc), .chip_enable(chip_enable),
      .ras_empty(ras_empty), .ras_full(ras_full), .ras_err(ras_err)
   );

   pc_gen #(
      .ADDR_W(8), .RESET_VECTOR(8'h0), .STEP(4),
      .TRAP_VECTOR(8'h80), .RAS_DEPTH(2)
   ) dut8 (
      .clk(clk), .rst(rst8), .stall(1'b0), .branch_flag(branch8),
      .branch_addr(addr8), .call_flag(1'b0), .ret_flag(1'b0),
      .trap(1'b0), .halt(1'b0), .pc(pc8), .chip_enable(ce8),
      .ras_empty(empty8), .ras_full(full8), .ras_err(err8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model: 0 = idle, 1 = run, 2 = halted
   int          mMode;
   logic [31:0] mPc;
   bit          mCe;
   bit          mErr;
   logic [31:0] mStack [$];

   always @(posedge clk) begin
      logic [31:0] retAddr;
      retAddr = mPc + 32'd4;
      mErr    = 1'b0;
      if (rst) begin
         mMode = 0;
         mPc   = 32'h0;
         mCe   = 1'b0;
         mStack.delete();
      end else if (mMode == 0) begin
         mMode = 1;
         mPc   = 32'h0;
         mCe   = 1'b0;
      end else if (mMode == 2) begin
         if (trap) begin
            mMode = 1;
            mPc   = 32'h100;
            mStack.delete();
         end
         mCe = (mMode == 1);
      end else begin
         if (trap) begin
            mPc = 32'h100;
            mStack.delete();
         end else if (stall) begin
            mPc = mPc;
         end else if (halt) begin
            mMode = 2;
         end else if (call_flag) begin
            if (ret_flag && mStack.size() > 0) begin
               mStack[mStack.size()-1] = retAddr;
            end else begin
               if (mStack.size() == 4) void'(mStack.pop_front());
               mStack.push_back(retAddr);
            end
            mPc = branch_addr;
         end else if (ret_flag) begin
            if (mStack.size() > 0) begin
               mPc = mStack.pop_back();
            end else begin
               mPc  = retAddr;
               mErr = 1'b1;
            end
         end else if (branch_flag) begin
            mPc = branch_addr;
         end else begin
            mPc = retAddr;
         end
         mCe = (mMode == 1);
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name,
                  actual, expected, $time);
      end
   endtask

   // Cycle-by-cycle comparison against the model
   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("model.pc", pc, mPc);
         checkOutput("model.chip_enable", 32'(chip_enable), 32'(mCe));
         checkOutput("model.ras_empty", 32'(ras_empty), 32'(mStack.size() == 0));
         checkOutput("model.ras_full", 32'(ras_full), 32'(mStack.size() == 4));
         checkOutput("model.ras_err", 32'(ras_err), 32'(mErr));
      end
   end

   // Drive one set of inputs and advance exactly one clock edge
   task automatic applyStimulus(input logic r, input logic st, input logic br,
                                input logic ca, input logic re, input logic tr,
                                input logic ha, input logic [31:0] addr);
      rst = r; stall = st; branch_flag = br; call_flag = ca;
      ret_flag = re; trap = tr; halt = ha; branch_addr = addr;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idleCycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 32'h0);
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; branch_flag = 1'b0; call_flag = 1'b0;
      ret_flag = 1'b0; trap = 1'b0; halt = 1'b0; branch_addr = '0;
      rst8 = 1'b1; branch8 = 1'b0; addr8 = '0;
      checkEn = 1'b1;

      // Reset for two cycles, then free-run
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 32'h0);
      checkOutput("rst1.pc", pc, 32'h0);
      checkOutput("rst1.ce", 32'(chip_enable), 32'h0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 32'h0);
      checkOutput("rst2.pc", pc, 32'h0);
      checkOutput("rst2.empty", 32'(ras_empty), 32'h1);
      idleCycle();
      checkOutput("start.pc0", pc, 32'h0);
      checkOutput("start.ce0", 32'(chip_enable), 32'h0);
      idleCycle();
      checkOutput("start.pc4", pc, 32'h4);
      checkOutput("start.ce4", 32'(chip_enable), 32'h1);
      idleCycle();
      checkOutput("start.pc8", pc, 32'h8);

      // Call then return
      applyStimulus(0, 0, 1, 0, 0, 0, 0, 32'h10);
      applyStimulus(0, 0, 0, 1, 0, 0, 0, 32'h200);
      checkOutput("call.pc", pc, 32'h200);
      checkOutput("call.empty", 32'(ras_empty), 32'h0);
      applyStimulus(0, 0, 0, 0, 1, 0, 0, 32'h0);
      checkOutput("ret.pc", pc, 32'h14);
      checkOutput("ret.empty", 32'(ras_empty), 32'h1);

      // Five calls overflow a four-deep stack, then five returns
      applyStimulus(0, 0, 1, 0, 0, 0, 0, 32'h0);
      for (int i = 1; i <= 5; i++) begin
         applyStimulus(0, 0, 0, 1, 0, 0, 0, 32'(i * 32'h100));
      end
      checkOutput("calls.pc", pc, 32'h500);
      checkOutput("calls.full", 32'(ras_full), 32'h1);
      applyStimulus(0, 0, 0, 0, 1, 0, 0, 32'h0);
      checkOutput("pop1", pc, 32'h404);
      applyStimulus(0, 0, 0, 0, 1, 0, 0, 32'h0);
      checkOutput("pop2", pc, 32'h304);
      applyStimulus(0, 0, 0, 0, 1, 0, 0, 32'h0);
      checkOutput("pop3", pc, 32'h204);
      applyStimulus(0, 0, 0, 0, 1, 0, 0, 32'h0);
      checkOutput("pop4", pc, 32'h104);
      applyStimulus(0, 0, 0, 0, 1, 0, 0, 32'h0);
      checkOutput("underflow.pc", pc, 32'h108);
      checkOutput("underflow.err", 32'(ras_err), 32'h1);
      idleCycle();
      checkOutput("underflow.errclr", 32'(ras_err), 32'h0);
      checkOutput("underflow.next", pc, 32'h10C);

      // Call with return replaces the top; on an empty stack it is a call
      applyStimulus(0, 0, 0, 1, 0, 0, 0, 32'h300);
      applyStimulus(0, 0, 0, 1, 1, 0, 0, 32'h600);
      checkOutput("callret.pc", pc, 32'h600);
      applyStimulus(0, 0, 0, 0, 1, 0, 0, 32'h0);
      checkOutput("callret.pop", pc, 32'h304);
      applyStimulus(0, 0, 0, 1, 1, 0, 0, 32'h700);
      checkOutput("callret_empty.pc", pc, 32'h700);
      applyStimulus(0, 0, 0, 0, 1, 0, 0, 32'h0);
      checkOutput("callret_empty.pop", pc, 32'h308);

      // Stall beats branch; trap beats stall and clears the stack
      applyStimulus(0, 0, 0, 1, 0, 0, 0, 32'h40);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 1, 1, 0, 0, 0, 0, 32'h999);
         checkOutput("stall.pc", pc, 32'h40);
      end
      applyStimulus(0, 1, 0, 0, 0, 1, 0, 32'h0);
      checkOutput("stalltrap.pc", pc, 32'h100);
      checkOutput("stalltrap.empty", 32'(ras_empty), 32'h1);

      // Stall suppresses halt
      applyStimulus(0, 1, 0, 0, 0, 0, 1, 32'h0);
      checkOutput("stallhalt.ce", 32'(chip_enable), 32'h1);

      // Halt, ignored inputs while halted, trap to leave
      applyStimulus(0, 0, 1, 0, 0, 0, 0, 32'h20);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h0);
      checkOutput("halt.pc", pc, 32'h20);
      checkOutput("halt.ce", 32'(chip_enable), 32'h0);
      applyStimulus(0, 0, 1, 0, 0, 0, 0, 32'h80);
      checkOutput("halted_branch.pc", pc, 32'h20);
      applyStimulus(0, 0, 0, 1, 1, 0, 0, 32'h90);
      checkOutput("halted_call.pc", pc, 32'h20);
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 32'h0);
      checkOutput("halted_trap.pc", pc, 32'h100);
      checkOutput("halted_trap.ce", 32'(chip_enable), 32'h1);

      // 32-bit wrap
      applyStimulus(0, 0, 1, 0, 0, 0, 0, 32'hFFFF_FFFC);
      idleCycle();
      checkOutput("wrap32.pc", pc, 32'h0);

      // Reset with a full stack and a pending trap
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 0, 0, 1, 0, 0, 0, 32'(32'h1000 + i * 32'h10));
      end
      checkOutput("prerst.full", 32'(ras_full), 32'h1);
      applyStimulus(1, 0, 0, 0, 0, 1, 0, 32'h0);
      checkOutput("midrst.pc", pc, 32'h0);
      checkOutput("midrst.ce", 32'(chip_enable), 32'h0);
      checkOutput("midrst.empty", 32'(ras_empty), 32'h1);
      idleCycle();
      idleCycle();
      checkOutput("midrst.run", pc, 32'h4);

      // 8-bit instance: wrap from 0xFC to 0x00
      rst8 = 1'b1;
      @(posedge clk); @(negedge clk);
      checkOutput("w8.rst", 32'(pc8), 32'h0);
      rst8 = 1'b0;
      @(posedge clk); @(negedge clk);
      branch8 = 1'b1; addr8 = 8'hFC;
      @(posedge clk); @(negedge clk);
      checkOutput("w8.branch", 32'(pc8), 32'hFC);
      branch8 = 1'b0;
      @(posedge clk); @(negedge clk);
      checkOutput("w8.wrap", 32'(pc8), 32'h00);
      checkOutput("w8.ce", 32'(ce8), 32'h1);
      @(posedge clk); @(negedge clk);
      checkOutput("w8.after", 32'(pc8), 32'h04);

      checkEn = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
